// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck core: opcode bytes, fetch FSM states and the
// classifier that separates data-path opcodes from control flow and comments.
package bf_pkg;

    localparam logic [7:0] OpInc       = 8'h2B;
    localparam logic [7:0] OpDec       = 8'h2D;
    localparam logic [7:0] OpLeft      = 8'h3C;
    localparam logic [7:0] OpRight     = 8'h3E;
    localparam logic [7:0] OpOut       = 8'h2E;
    localparam logic [7:0] OpIn        = 8'h2C;
    localparam logic [7:0] OpLoopOpen  = 8'h5B;
    localparam logic [7:0] OpLoopClose = 8'h5D;
    localparam logic [7:0] OpNul       = 8'h00;

    typedef enum logic [1:0] {
        StFetch,
        StScan,
        StHalt,
        StError
    } fetch_state_e;

    function automatic logic is_datapath_op(input logic [7:0] op);
        return (op == OpInc) || (op == OpDec) || (op == OpLeft) ||
               (op == OpRight) || (op == OpOut) || (op == OpIn);
    endfunction

endpackage

// File: rtl/bf_loop_stack.sv
// Parameterised LIFO holding loop return addresses. A simultaneous push and pop on a
// non-empty stack overwrites the top entry in place.
module bf_loop_stack #(
    parameter int unsigned c_depth = 16,
    parameter int unsigned c_width = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [c_width-1:0] din_i,
    output logic [c_width-1:0] top_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int unsigned SpW  = $clog2(c_depth + 1);
    localparam int unsigned IdxW = $clog2(c_depth);

    logic [c_width-1:0] mem_q [c_depth];
    logic [SpW-1:0]     sp_q, sp_d;
    logic [IdxW-1:0]    top_idx, wr_idx;
    logic               wr_en;

    assign empty_o = (sp_q == '0);
    assign full_o  = (sp_q == SpW'(c_depth));
    assign top_idx = IdxW'(sp_q - SpW'(1));
    assign top_o   = empty_o ? '0 : mem_q[top_idx];

    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        wr_idx = IdxW'(sp_q);
        if (push_i && pop_i && !empty_o) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push_i && !full_o) begin
            // Push+pop on an empty stack degenerates to a plain push.
            wr_en = 1'b1;
            sp_d  = sp_q + SpW'(1);
        end else if (pop_i && !push_i && !empty_o) begin
            sp_d = sp_q - SpW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= din_i;
        end
    end

endmodule

// File: rtl/bf_fetch_unit.sv
// Fetch and loop-control stage: walks the program ROM, resolves brackets locally and
// hands data-path opcodes downstream. Define BF_FETCH_STATS_EN to add o_retired/o_jumps.
module bf_fetch_unit #(
    parameter int unsigned c_addr_width  = 8,
    parameter int unsigned c_data_width  = 8,
    parameter int unsigned c_stack_depth = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    output logic [c_addr_width-1:0] o_rom_addr,
    input  logic [c_data_width-1:0] i_rom_data,
    output logic                    o_valid,
    output logic [c_data_width-1:0] o_instr,
    input  logic                    i_ready,
    input  logic                    i_cell_zero,
    output logic [c_addr_width-1:0] o_pc,
    output logic                    o_halt,
    output logic                    o_error
`ifdef BF_FETCH_STATS_EN
    ,
    output logic [31:0]             o_retired,
    output logic [31:0]             o_jumps
`endif
);

    import bf_pkg::*;

    fetch_state_e            state_q, state_d;
    logic [c_addr_width-1:0] pc_q, pc_d, pc_inc;
    logic                    pc_last;
    logic [c_addr_width:0]   depth_q, depth_d;
    logic [7:0]              op;
    logic                    valid;
    logic                    push, pop;
    logic [c_addr_width-1:0] stk_top;
    logic                    stk_empty, stk_full;

    assign op      = i_rom_data[7:0];
    assign pc_inc  = pc_q + c_addr_width'(1);
    assign pc_last = &pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        push    = 1'b0;
        pop     = 1'b0;
        valid   = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (is_datapath_op(op)) begin
                    valid = 1'b1;
                    if (i_ready) begin
                        if (pc_last) state_d = StHalt;
                        else         pc_d    = pc_inc;
                    end
                end else if (op == OpLoopOpen) begin
                    if (i_ready) begin
                        if (i_cell_zero) begin
                            if (pc_last) begin
                                state_d = StHalt;
                            end else begin
                                state_d = StScan;
                                depth_d = (c_addr_width + 1)'(1);
                                pc_d    = pc_inc;
                            end
                        end else if (stk_full) begin
                            state_d = StError;
                        end else if (pc_last) begin
                            state_d = StHalt;
                        end else begin
                            push = 1'b1;
                            pc_d = pc_inc;
                        end
                    end
                end else if (op == OpLoopClose) begin
                    if (i_ready) begin
                        if (stk_empty) begin
                            state_d = StError;
                        end else if (!i_cell_zero) begin
                            pc_d = stk_top;
                        end else begin
                            pop = 1'b1;
                            if (pc_last) state_d = StHalt;
                            else         pc_d    = pc_inc;
                        end
                    end
                end else if (op == OpNul) begin
                    state_d = StHalt;
                end else begin
                    // Comment bytes never stall on the execute stage.
                    if (pc_last) state_d = StHalt;
                    else         pc_d    = pc_inc;
                end
            end
            StScan: begin
                if (op == OpNul || pc_last) begin
                    state_d = StError;
                end else begin
                    pc_d = pc_inc;
                    if (op == OpLoopOpen) begin
                        depth_d = depth_q + (c_addr_width + 1)'(1);
                    end else if (op == OpLoopClose) begin
                        depth_d = depth_q - (c_addr_width + 1)'(1);
                        if (depth_q == (c_addr_width + 1)'(1)) state_d = StFetch;
                    end
                end
            end
            StHalt, StError: begin
            end
            default: state_d = StError;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

    bf_loop_stack #(
        .c_depth (c_stack_depth),
        .c_width (c_addr_width)
    ) u_loop_stack (
        .clk_i   (i_clock),
        .rst_i   (i_reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (pc_inc),
        .top_o   (stk_top),
        .empty_o (stk_empty),
        .full_o  (stk_full)
    );

    assign o_rom_addr = pc_q;
    assign o_pc       = pc_q;
    assign o_instr    = i_rom_data;
    assign o_valid    = valid & ~i_reset;
    assign o_halt     = (state_q == StHalt);
    assign o_error    = (state_q == StError);

`ifdef BF_FETCH_STATS_EN
    logic        stat_retire, stat_jump;
    logic [31:0] retired_q, jumps_q;

    assign stat_retire = o_valid & i_ready;
    assign stat_jump   = (state_q == StFetch) &&
                         ((state_d == StScan) ||
                          (i_ready && op == OpLoopClose && !stk_empty && !i_cell_zero));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            retired_q <= '0;
            jumps_q   <= '0;
        end else begin
            if (stat_retire && retired_q != '1) retired_q <= retired_q + 32'd1;
            if (stat_jump && jumps_q != '1)     jumps_q   <= jumps_q + 32'd1;
        end
    end

    assign o_retired = retired_q;
    assign o_jumps   = jumps_q;
`endif

endmodule

// File: tb/tb_bf_fetch_unit.sv
// Directed self-checking bench for bf_fetch_unit, plus a standalone check of the loop
// stack's push+pop replace path.
module tb_bf_fetch_unit;

    logic       clk;
    logic       i_reset;
    logic [7:0] o_rom_addr;
    logic [7:0] i_rom_data;
    logic       o_valid;
    logic [7:0] o_instr;
    logic       i_ready;
    logic       i_cell_zero;
    logic [7:0] o_pc;
    logic       o_halt;
    logic       o_error;
`ifdef BF_FETCH_STATS_EN
    logic [31:0] o_retired;
    logic [31:0] o_jumps;
`endif

    logic [7:0] rom [256];
    int checks;
    int errors;

    logic       s_rst, s_push, s_pop;
    logic [7:0] s_din, s_top;
    logic       s_empty, s_full;

    assign i_rom_data = rom[o_rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bf_fetch_unit #(
        .c_addr_width  (8),
        .c_data_width  (8),
        .c_stack_depth (16)
    ) dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (i_rom_data),
        .o_valid     (o_valid),
        .o_instr     (o_instr),
        .i_ready     (i_ready),
        .i_cell_zero (i_cell_zero),
        .o_pc        (o_pc),
        .o_halt      (o_halt),
        .o_error     (o_error)
`ifdef BF_FETCH_STATS_EN
        ,
        .o_retired   (o_retired),
        .o_jumps     (o_jumps)
`endif
    );

    bf_loop_stack #(
        .c_depth (4),
        .c_width (8)
    ) u_stack (
        .clk_i   (clk),
        .rst_i   (s_rst),
        .push_i  (s_push),
        .pop_i   (s_pop),
        .din_i   (s_din),
        .top_o   (s_top),
        .empty_o (s_empty),
        .full_o  (s_full)
    );

    task automatic load(input string prog);
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < prog.len(); i++) rom[i] = prog[i];
    endtask

    // Leaves the bench at a sample point (negedge + 1) with the DUT freshly out of reset.
    task automatic do_reset(input string prog);
        i_reset = 1'b1;
        i_ready = 1'b0;
        i_cell_zero = 1'b0;
        load(prog);
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
    endtask

    task automatic run_to_end(input logic cz, input int max_cycles,
                              output int xfers, output int cycles);
        xfers = 0;
        cycles = 0;
        i_ready = 1'b1;
        i_cell_zero = cz;
        while (!o_halt && !o_error && cycles < max_cycles) begin
            if (o_valid && i_ready) xfers++;
            @(negedge clk);
            #1;
            cycles++;
        end
        checks++;
        if (!o_halt && !o_error) begin
            errors++;
            $display("FAIL run_to_end: no halt/error after %0d cycles", cycles);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_ready = 1'b1;
        i_cell_zero = 1'b0;
        load("+");
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_pc !== 8'd0 || o_halt !== 1'b0 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b pc=%0d halt=%b err=%b, want 0/0/0/0",
                     o_valid, o_pc, o_halt, o_error);
        end
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_instr !== 8'h2B) begin
            errors++;
            $display("FAIL reset_release: valid=%b instr=%h, want 1/2b", o_valid, o_instr);
        end
    endtask

    task automatic test_datapath();
        logic [7:0] exp [3];
        exp = '{8'h2B, 8'h3E, 8'h2D};
        do_reset("+>-");
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_instr !== exp[i] || o_pc !== 8'(i)) begin
                errors++;
                $display("FAIL datapath_%0d: valid=%b instr=%h pc=%0d, want 1/%h/%0d",
                         i, o_valid, o_instr, o_pc, exp[i], i);
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (o_valid !== 1'b0 || o_pc !== 8'd3) begin
            errors++;
            $display("FAIL datapath_nul: valid=%b pc=%0d, want 0/3", o_valid, o_pc);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_halt !== 1'b1 || o_error !== 1'b0 || o_pc !== 8'd3) begin
            errors++;
            $display("FAIL datapath_halt: halt=%b err=%b pc=%0d, want 1/0/3",
                     o_halt, o_error, o_pc);
        end
    endtask

    task automatic test_all_ops();
        string prog;
        logic  exp_valid;
        prog = "+-<>x.,";
        do_reset(prog);
        i_ready = 1'b1;
        for (int i = 0; i < prog.len(); i++) begin
            exp_valid = (prog[i] != "x");
            checks++;
            if (o_valid !== exp_valid || o_pc !== 8'(i) ||
                (exp_valid && o_instr !== prog[i])) begin
                errors++;
                $display("FAIL all_ops_%0d: valid=%b instr=%h pc=%0d, want %b/%h/%0d",
                         i, o_valid, o_instr, o_pc, exp_valid, prog[i], i);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        int x;
        int c;
        do_reset("+a+");
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_instr !== 8'h2B || o_pc !== 8'd0) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b instr=%h pc=%0d, want 1/2b/0",
                         i, o_valid, o_instr, o_pc);
            end
            @(negedge clk);
            #1;
        end
        i_ready = 1'b1;
        @(negedge clk);
        #1;
        i_ready = 1'b0;
        checks++;
        if (o_pc !== 8'd1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: pc=%0d valid=%b, want 1/0", o_pc, o_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_pc !== 8'd2) begin
            errors++;
            $display("FAIL stall_comment: pc=%0d, want 2", o_pc);
        end
        run_to_end(1'b0, 20, x, c);
        checks++;
        if (1 + x !== 2 || o_halt !== 1'b1) begin
            errors++;
            $display("FAIL stall_total: transfers=%0d halt=%b, want 2/1", 1 + x, o_halt);
        end
    endtask

    task automatic test_loop_skip();
        int x;
        int c;
        do_reset("[+]");
        run_to_end(1'b1, 20, x, c);
        checks++;
        if (x !== 0 || o_pc !== 8'd3 || o_halt !== 1'b1 || c !== 4) begin
            errors++;
            $display("FAIL loop_skip: xfers=%0d pc=%0d halt=%b cycles=%0d, want 0/3/1/4",
                     x, o_pc, o_halt, c);
        end
    endtask

    task automatic test_loop_iter();
        int xfers;
        int visits;
        int cycles;
        do_reset("[+]");
        i_ready = 1'b1;
        xfers = 0;
        visits = 0;
        cycles = 0;
        while (!o_halt && !o_error && cycles < 40) begin
            i_cell_zero = (rom[o_rom_addr] == 8'h5D) && (visits >= 2);
            #1;
            if (o_valid) begin
                xfers++;
                checks++;
                if (o_instr !== 8'h2B) begin
                    errors++;
                    $display("FAIL loop_iter_instr: instr=%h, want 2b", o_instr);
                end
            end
            if (rom[o_rom_addr] == 8'h5D) visits++;
            @(negedge clk);
            #1;
            cycles++;
        end
        checks++;
        if (xfers !== 3 || visits !== 3 || o_halt !== 1'b1 || o_pc !== 8'd3 || cycles !== 8) begin
            errors++;
            $display("FAIL loop_iter: xfers=%0d visits=%0d halt=%b pc=%0d cycles=%0d, want 3/3/1/3/8",
                     xfers, visits, o_halt, o_pc, cycles);
        end
    endtask

    task automatic test_nested();
        int x;
        int c;
        do_reset("[[]]+");
        i_ready = 1'b1;
        i_cell_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (o_pc !== 8'd4 || o_valid !== 1'b1 || o_instr !== 8'h2B) begin
            errors++;
            $display("FAIL nested_skip: pc=%0d valid=%b instr=%h, want 4/1/2b",
                     o_pc, o_valid, o_instr);
        end
        run_to_end(1'b1, 20, x, c);
        checks++;
        if (x !== 1 || o_halt !== 1'b1 || o_pc !== 8'd5) begin
            errors++;
            $display("FAIL nested_end: xfers=%0d halt=%b pc=%0d, want 1/1/5", x, o_halt, o_pc);
        end
    endtask

    task automatic test_errors();
        int         x;
        int         c;
        string      progs [3];
        logic       czs [3];
        logic [7:0] exp_pc [3];
        string      deep;
        deep = "";
        for (int i = 0; i < 17; i++) deep = {deep, "["};
        progs  = '{"]", "[", deep};
        czs    = '{1'b0, 1'b1, 1'b0};
        exp_pc = '{8'd0, 8'd1, 8'd16};
        for (int k = 0; k < 3; k++) begin
            do_reset(progs[k]);
            run_to_end(czs[k], 60, x, c);
            checks++;
            if (o_error !== 1'b1 || o_halt !== 1'b0 || o_pc !== exp_pc[k]) begin
                errors++;
                $display("FAIL error_case_%0d: err=%b halt=%b pc=%0d, want 1/0/%0d",
                         k, o_error, o_halt, o_pc, exp_pc[k]);
            end
            @(negedge clk);
            #1;
            checks++;
            if (o_error !== 1'b1 || o_pc !== exp_pc[k] || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL error_sticky_%0d: err=%b pc=%0d valid=%b, want 1/%0d/0",
                         k, o_error, o_pc, o_valid, exp_pc[k]);
            end
        end
    endtask

    task automatic test_reset_scan();
        int x;
        int c;
        do_reset("[[[]]]");
        i_ready = 1'b1;
        i_cell_zero = 1'b1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (o_pc !== 8'd2) begin
            errors++;
            $display("FAIL reset_scan_pre: pc=%0d, want 2", o_pc);
        end
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_pc !== 8'd0 || o_valid !== 1'b0 || o_halt !== 1'b0 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_scan_async: pc=%0d valid=%b halt=%b err=%b, want 0/0/0/0",
                     o_pc, o_valid, o_halt, o_error);
        end
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        run_to_end(1'b1, 30, x, c);
        checks++;
        if (o_halt !== 1'b1 || o_error !== 1'b0 || o_pc !== 8'd6 || x !== 0 || c !== 7) begin
            errors++;
            $display("FAIL reset_scan_rerun: halt=%b err=%b pc=%0d xfers=%0d cycles=%0d, want 1/0/6/0/7",
                     o_halt, o_error, o_pc, x, c);
        end
    endtask

    task automatic test_stack_replace();
        logic       ops_push [10];
        logic       ops_pop [10];
        logic [7:0] ops_din [10];
        logic [7:0] exp_top [10];
        logic       exp_full [10];
        logic       exp_empty [10];
        ops_push  = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
        ops_pop   = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        ops_din   = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        exp_top   = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h44, 8'h55, 8'h66, 8'h66, 8'h88, 8'h55};
        exp_full  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        exp_empty = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        s_push = 1'b0;
        s_pop = 1'b0;
        s_din = 8'h00;
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        #1;
        checks++;
        if (s_empty !== 1'b1 || s_full !== 1'b0 || s_top !== 8'h00) begin
            errors++;
            $display("FAIL stack_reset: empty=%b full=%b top=%h, want 1/0/00",
                     s_empty, s_full, s_top);
        end
        for (int i = 0; i < 10; i++) begin
            s_push = ops_push[i];
            s_pop = ops_pop[i];
            s_din = ops_din[i];
            @(negedge clk);
            #1;
            checks++;
            if (s_top !== exp_top[i] || s_full !== exp_full[i] || s_empty !== exp_empty[i]) begin
                errors++;
                $display("FAIL stack_op_%0d: top=%h full=%b empty=%b, want %h/%b/%b",
                         i, s_top, s_full, s_empty, exp_top[i], exp_full[i], exp_empty[i]);
            end
        end
        s_push = 1'b0;
        s_pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
        end
        s_pop = 1'b0;
        checks++;
        if (s_empty !== 1'b1) begin
            errors++;
            $display("FAIL stack_drain: empty=%b, want 1", s_empty);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_reset = 1'b1;
        i_ready = 1'b0;
        i_cell_zero = 1'b0;
        s_rst = 1'b1;
        s_push = 1'b0;
        s_pop = 1'b0;
        s_din = 8'h00;
        load("");
        @(negedge clk);
        test_reset();
        test_datapath();
        test_all_ops();
        test_stall();
        test_loop_skip();
        test_loop_iter();
        test_nested();
        test_errors();
        test_reset_scan();
        test_stack_replace();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
